// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Shared MIPS datapath types and architectural register numbers.
// Rev    : 1.0
// ============================================================================
package mips_pkg;
  localparam int WIDTH      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]      word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_GP   = 5'd28;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module : rf_read_port
// One register-file read port: address decode, $zero forcing, write bypass.
// Rev    : 1.0
// ============================================================================
module rf_read_port #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [(1<<DEPTH_LOG2)-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH_LOG2-1:0]                 addr,
  input  logic                                  wr_commit,
  input  logic [DEPTH_LOG2-1:0]                 wr_addr,
  input  logic [WIDTH-1:0]                      wr_data,
  output logic [WIDTH-1:0]                      data
);
  logic w_hit;

  // wr_commit already excludes reset and register 0
  assign w_hit = BYPASS && wr_commit && (wr_addr == addr);

  always_comb begin
    data = regs[addr];
    if (w_hit) data = wr_data;
    if (addr == '0) data = '0;
  end
endmodule
`default_nettype wire

// File: rtl/reg_file_mips.sv
`default_nettype none
// ============================================================================
// Module : reg_file_mips
// 32 x 32 MIPS register file with bypass, hardwired $zero and debug port.
// Rev    : 1.0
// ============================================================================
module reg_file_mips #(
  parameter int          WIDTH      = 32,
  parameter int          DEPTH_LOG2 = 5,
  parameter logic [31:0] SP_RESET   = 32'h0000_3FFC,
  parameter logic [31:0] GP_RESET   = 32'h0000_1800,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] rs_addr,
  input  logic [DEPTH_LOG2-1:0] rt_addr,
  output logic [WIDTH-1:0]      rs_data,
  output logic [WIDTH-1:0]      rt_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [WIDTH-1:0]      dbg_data,
  output logic [15:0]           wr_count
);
  import mips_pkg::*;

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [c_depth-1:0][WIDTH-1:0] r_regs;
  logic [15:0]                   r_count;
  logic                          w_commit;

  // An X on wr_en evaluates false here, so it never commits a write
  assign w_commit = !reset && (wr_en == 1'b1) && (wr_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs         <= '0;
      r_regs[REG_GP] <= GP_RESET[WIDTH-1:0];
      r_regs[REG_SP] <= SP_RESET[WIDTH-1:0];
    end else if (w_commit) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_commit && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign wr_count = r_count;

  rf_read_port #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(BYPASS)) u_rs_port (
    .regs      (r_regs),
    .addr      (rs_addr),
    .wr_commit (w_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data      (rs_data)
  );

  rf_read_port #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(BYPASS)) u_rt_port (
    .regs      (r_regs),
    .addr      (rt_addr),
    .wr_commit (w_commit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data      (rt_data)
  );

  // Debug port always shows stored state
  rf_read_port #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(1'b0)) u_dbg_port (
    .regs      (r_regs),
    .addr      (dbg_addr),
    .wr_commit (1'b0),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data      (dbg_data)
  );
endmodule
`default_nettype wire
